// File: rtl/rib_pkg.sv
// Shared definitions for the RIB bus arbiter: FSM state encoding,
// master slot assignments and default bus geometry.
package rib_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    // Fixed master slot assignments on the RIB
    localparam int M_IF   = 0;  // instruction fetch
    localparam int M_LSU  = 1;  // core load/store
    localparam int M_JTAG = 2;  // debug module

    // Default bus geometry
    localparam int RIB_NUM_M   = 3;
    localparam int RIB_AW      = 32;
    localparam int RIB_DW      = 32;
    localparam int RIB_TIMEOUT = 16;

endpackage

// File: rtl/rib_arbiter_rr_pick.sv
// Combinational round-robin winner select. Searches req starting at
// index ptr and wrapping modulo N; returns the first set index found.
// Written for non-power-of-two N, so the wrap uses an explicit compare
// rather than relying on natural overflow. ptr must be below N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // One extra bit so ptr + offset cannot overflow before the wrap
    logic [IW:0] cand;

    // Scan offsets 0..N-1 from ptr, keep the first requester hit
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand > (IW+1)'(N - 1)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter. Grants the single shared slave port to one of NUM_M
// masters at a time in round-robin order, latches the winner's request
// onto the slave side for the duration of the transaction, and converts
// a slave that never answers into an error response after TIMEOUT cycles
// so the requesting pipeline stage cannot deadlock.
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int NUM_M   = RIB_NUM_M,
    parameter int AW      = RIB_AW,
    parameter int DW      = RIB_DW,
    parameter int TIMEOUT = RIB_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_wdata_i,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [DW-1:0]       m_rdata_o,
    output logic [NUM_M-1:0]    m_stall_o,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_wdata_o,
    input  logic [DW-1:0]       s_rdata_i,
    input  logic                s_ack_i,

    output logic                busy_o
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int TW = $clog2(TIMEOUT);

    arb_state_e    state;
    arb_state_e    state_next;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [TW-1:0] timer;
    logic          timer_last;

    // Successor of a master index, wrapping at NUM_M-1 explicitly
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] g);
        return (g == IW'(NUM_M - 1)) ? '0 : g + IW'(1);
    endfunction

    assign timer_last = (timer == TW'(TIMEOUT - 1));

    rr_pick #(
        .N  (NUM_M),
        .IW (IW)
    ) u_pick (
        .req   (m_req_i),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack in the final timer cycle beats the timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (s_ack_i) begin
                    state_next = IDLE;
                end else if (timer_last) begin
                    state_next = ERR;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Master-side responses, combinational so the ack lands in the slave ack cycle
    always_comb begin
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rdata_o = '0;
        if (!rst_i) begin
            if (state == BUSY && s_ack_i) begin
                m_ack_o[grant] = 1'b1;
                m_rdata_o      = s_rdata_i;
            end else if (state == ERR) begin
                m_ack_o[grant] = 1'b1;
                m_err_o[grant] = 1'b1;
            end
        end
    end

    // A master stalls while it requests and is not being acked this cycle
    assign m_stall_o = m_req_i & ~m_ack_o;

    // Grant, round-robin pointer, timeout timer and latched slave request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr    <= '0;
            grant     <= '0;
            timer     <= '0;
            s_req_o   <= 1'b0;
            s_we_o    <= 1'b0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            busy_o <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_idx;
                        s_req_o   <= 1'b1;
                        s_we_o    <= m_we_i[pick_idx];
                        s_addr_o  <= m_addr_i[int'(pick_idx)*AW +: AW];
                        s_wdata_o <= m_wdata_i[int'(pick_idx)*DW +: DW];
                        timer     <= '0;
                    end
                end
                BUSY: begin
                    timer <= timer + TW'(1);
                    if (s_ack_i) begin
                        s_req_o <= 1'b0;
                        rr_ptr  <= wrap_inc(grant);
                    end else if (timer_last) begin
                        s_req_o <= 1'b0;
                    end
                end
                ERR: begin
                    rr_ptr <= wrap_inc(grant);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter. The stimulus thread drives masters and
// the slave, checks registered slave-side outputs, and queues the master
// response it expects; a negedge monitor pops and compares every master
// ack/err it sees.
module tb_rib_arbiter;
    import rib_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk;
    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic [DW-1:0]    m_rdata;
    logic [NM-1:0]    m_stall;
    logic             s_req;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [DW-1:0]    s_rdata;
    logic             s_ack;
    logic             busy;

    typedef struct {
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    rib_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .m_rdata_o (m_rdata),
        .m_stall_o (m_stall),
        .s_req_o   (s_req),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_rdata_i (s_rdata),
        .s_ack_i   (s_ack),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NM-1:0] a, input logic [NM-1:0] e, input logic [DW-1:0] d);
        exp_t x;
        x.ack   = a;
        x.err   = e;
        x.rdata = d;
        q.push_back(x);
    endtask

    // Response monitor: every ack/err pulse must match the next queued response
    always @(negedge clk) begin
        if (m_ack != '0 || m_err != '0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: ack=%b err=%b rdata=0x%0h, none expected", m_ack, m_err, m_rdata);
            end else begin
                mon_e = q.pop_front();
                check("resp_ack", 64'(m_ack), 64'(mon_e.ack));
                check("resp_err", 64'(m_err), 64'(mon_e.err));
                check("resp_rdata", 64'(m_rdata), 64'(mon_e.rdata));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ack   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_s_req", 64'(s_req), 64'd0);
        check("rst_s_addr", 64'(s_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_m_ack", 64'(m_ack), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        check("rst_m_rdata", 64'(m_rdata), 64'd0);
        rst = 1'b0;

        // Round-robin: all masters request continuously, slave acks at once
        m_addr[M_IF*AW   +: AW] = 32'h1000;
        m_addr[M_LSU*AW  +: AW] = 32'h2000;
        m_addr[M_JTAG*AW +: AW] = 32'h3000;
        m_req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_s_req", 64'(s_req), 64'd1);
            check("rr_s_addr", 64'(s_addr), 64'(32'h1000 * ((i % 3) + 1)));
            check("rr_stall_wait", 64'(m_stall), 64'b111);
            s_ack   = 1'b1;
            s_rdata = 32'hA0 + 32'(i);
            push(3'b001 << (i % 3), 3'b000, 32'hA0 + 32'(i));
            #1;
            check("rr_stall_ack", 64'(m_stall), 64'(3'b111 & ~(3'b001 << (i % 3))));
            tick();
            s_ack = 1'b0;
            check("rr_idle_s_req", 64'(s_req), 64'd0);
            check("rr_idle_busy", 64'(busy), 64'd0);
        end
        m_req = '0;
        tick();

        // Single read from load/store, slave acks two cycles after s_req
        m_req = 3'b010;
        m_we  = 3'b000;
        m_addr[M_LSU*AW +: AW] = 32'h100;
        tick();
        check("rd_s_req", 64'(s_req), 64'd1);
        check("rd_s_addr", 64'(s_addr), 64'h100);
        check("rd_s_we", 64'(s_we), 64'd0);
        check("rd_busy", 64'(busy), 64'd1);
        check("rd_stall", 64'(m_stall), 64'b010);
        tick();
        tick();
        s_ack   = 1'b1;
        s_rdata = 32'hDEADBEEF;
        push(3'b010, 3'b000, 32'hDEADBEEF);
        tick();
        s_ack = 1'b0;
        m_req = '0;
        check("rd_done_s_req", 64'(s_req), 64'd0);
        tick();

        // Timeout: jtag writes 0x2000, slave never answers
        m_req = 3'b100;
        m_we  = 3'b100;
        m_addr[M_JTAG*AW +: AW]  = 32'h2000;
        m_wdata[M_JTAG*DW +: DW] = 32'h55AA;
        tick();
        check("to_s_req", 64'(s_req), 64'd1);
        check("to_s_we", 64'(s_we), 64'd1);
        check("to_s_addr", 64'(s_addr), 64'h2000);
        check("to_s_wdata", 64'(s_wdata), 64'h55AA);
        for (int i = 0; i < 15; i++) tick();
        check("to_last_s_req", 64'(s_req), 64'd1);
        push(3'b100, 3'b100, 32'h0);
        tick();
        check("to_err_s_req", 64'(s_req), 64'd0);
        check("to_err_busy", 64'(busy), 64'd1);
        tick();
        m_we  = '0;
        m_req = 3'b111;
        check("to_idle_busy", 64'(busy), 64'd0);
        tick();
        check("to_next_grant_addr", 64'(s_addr), 64'h1000);
        s_ack   = 1'b1;
        s_rdata = 32'h11;
        push(3'b001, 3'b000, 32'h11);
        tick();
        s_ack = 1'b0;
        m_req = '0;
        tick();

        // Ack arrives exactly in the last timer cycle: ack wins, no error
        m_req = 3'b010;
        m_addr[M_LSU*AW +: AW] = 32'h300;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("co_s_req", 64'(s_req), 64'd1);
        s_ack   = 1'b1;
        s_rdata = 32'hC0FFEE00;
        push(3'b010, 3'b000, 32'hC0FFEE00);
        tick();
        s_ack = 1'b0;
        m_req = '0;
        check("co_busy", 64'(busy), 64'd0);
        check("co_s_req_low", 64'(s_req), 64'd0);
        tick();

        // Request withdrawn: ifetch drops req while its address changes
        m_req = 3'b001;
        m_addr[M_IF*AW +: AW] = 32'h40;
        tick();
        check("wd_s_addr", 64'(s_addr), 64'h40);
        m_req = 3'b000;
        m_addr[M_IF*AW +: AW] = 32'h44;
        tick();
        check("wd_s_addr_held", 64'(s_addr), 64'h40);
        check("wd_s_req_held", 64'(s_req), 64'd1);
        s_ack   = 1'b1;
        s_rdata = 32'h12345678;
        push(3'b001, 3'b000, 32'h12345678);
        tick();
        s_ack = 1'b0;
        tick();

        // Reset mid-transaction with jtag requesting throughout
        m_req = 3'b100;
        tick();
        check("mr_s_req", 64'(s_req), 64'd1);
        rst = 1'b1;
        tick();
        check("mr_s_req_rst", 64'(s_req), 64'd0);
        check("mr_s_addr_rst", 64'(s_addr), 64'd0);
        check("mr_s_we_rst", 64'(s_we), 64'd0);
        check("mr_s_wdata_rst", 64'(s_wdata), 64'd0);
        check("mr_busy_rst", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        check("mr_regrant_s_req", 64'(s_req), 64'd1);
        check("mr_regrant_addr", 64'(s_addr), 64'h2000);
        s_ack   = 1'b1;
        s_rdata = 32'h77;
        push(3'b100, 3'b000, 32'h77);
        tick();
        s_ack = 1'b0;
        m_req = '0;
        tick();
        tick();

        check("pending_responses", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Arbitrates the shared RIB memory bus between NUM_M bus masters: instruction fetch, core load/store and debug (JTAG).
- Runs one transaction at a time. Masters are granted in round-robin order. While a transaction is outstanding, the winning master's request is latched and held on the slave side.
- Drives per-master stall flags, which ctrl consumes as hold_flag_rib_i.
- Times out unresponsive slaves and returns an error response so the pipeline never deadlocks.

Parameters:
- NUM_M, 3, number of masters (index 0 = ifetch, 1 = load/store, 2 = jtag).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, cycles to wait for s_ack_i before forcing an error response (≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- m_req_i  in  NUM_M  per-master request; held high until that master's m_ack_o.
- m_we_i  in  NUM_M  per-master write enable.
- m_addr_i  in  NUM_M*AW  packed addresses; master k occupies [k*AW +: AW].
- m_wdata_i  in  NUM_M*DW  packed write data.
- m_ack_o  out  NUM_M  one-cycle completion pulse to the granted master.
- m_err_o  out  NUM_M  one-cycle error pulse, coincident with m_ack_o on timeout.
- m_rdata_o  out  DW  read data, valid while any m_ack_o bit is high.
- m_stall_o  out  NUM_M  m_req_i[k] & ~m_ack_o[k].
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  AW  slave address.
- s_wdata_o  out  DW  slave write data.
- s_rdata_i  in  DW  slave read data.
- s_ack_i  in  1  slave completion; sampled only while state is BUSY.
- busy_o  out  1  high in BUSY and ERR.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state ← IDLE; rr_ptr ← 0; grant ← 0; timer ← 0.
  - s_req_o, s_we_o, s_addr_o, s_wdata_o ← 0.
  - m_ack_o, m_err_o, m_rdata_o ← 0; busy_o ← 0.
  - Reset mid-transaction abandons it silently: no ack or err is issued.
- FSM states: IDLE, BUSY, ERR.
- IDLE:
  - If any m_req_i is set, pick the winner: the first requesting index found searching rr_ptr, rr_ptr+1, … modulo NUM_M.
  - Register grant, latch that master's we/addr/wdata into the s_* registers, assert s_req_o, clear timer, go to BUSY.
  - Latency: request in cycle t → s_req_o high in cycle t+1.
- BUSY:
  - s_req_o is held high with the latched fields; later changes on m_* inputs are ignored.
  - timer increments once per cycle.
  - When s_ack_i = 1:
    - m_ack_o[grant] = 1 combinationally in the same cycle; m_rdata_o = s_rdata_i.
    - Next state IDLE; s_req_o ← 0; rr_ptr ← (grant+1) mod NUM_M.
  - When timer = TIMEOUT-1 and s_ack_i = 0: next state ERR; s_req_o ← 0.
  - If s_ack_i and timeout occur in the same cycle, the ack wins.
- ERR (exactly one cycle):
  - m_ack_o[grant] = 1, m_err_o[grant] = 1, m_rdata_o = 0.
  - rr_ptr ← grant+1; next state IDLE.
- Back-to-back operation: IDLE is always visited for one cycle between transactions, giving a minimum of 2 cycles per transaction.
- A master that drops m_req_i mid-transaction still receives its ack pulse and must ignore it.
- s_ack_i arriving in IDLE or ERR is ignored.
- All outputs other than m_ack_o, m_err_o, m_rdata_o and m_stall_o are registered.
- The wrap-around of rr_ptr uses an explicit compare against NUM_M-1, so non-power-of-two NUM_M is supported.

Decomposition:
- rib_pkg holds:
  - state enum arb_state_e {IDLE, BUSY, ERR};
  - master index localparams M_IF = 0, M_LSU = 1, M_JTAG = 2;
  - bus width defaults.
- One sub-module, rr_pick: a combinational round-robin winner select (inputs req and ptr, outputs idx and valid). It is reused later for the interrupt-source selector.

Test Plan:
- Single read: m_req_i = 3'b010, addr1 = 0x100, slave acks 2 cycles after s_req_o with s_rdata_i = 0xDEADBEEF.
  - Expect s_req_o at t+1 and s_addr_o = 0x100.
  - Expect m_ack_o = 3'b010 and m_rdata_o = 0xDEADBEEF in the ack cycle.
- Round-robin fairness: all three masters request continuously, slave acks immediately.
  - Expect grant order 0,1,2,0,1,2.
  - Expect m_stall_o to hold high for each waiting master.
- Timeout: master 2 writes to 0x2000 and the slave never acks.
  - Expect s_req_o low after 16 cycles.
  - Expect m_ack_o = m_err_o = 3'b100 for one cycle; next grant comes from rr_ptr = 0.
- Ack and timeout coincide: s_ack_i rises exactly in the TIMEOUT-1 cycle.
  - Expect m_ack_o high with m_err_o = 0 and m_rdata_o = s_rdata_i.
- Reset mid-transaction: rst_i asserted in BUSY.
  - Expect all outputs at 0 the next cycle, with no ack or err issued.
  - With m_req_i = 3'b100 held, the following grant is master 2.
- Request withdrawn: master 0 drops m_req_i one cycle into BUSY while m_addr_i changes to 0x44.
  - Expect s_addr_o to keep the latched value and m_ack_o[0] still to pulse.
